// File: rtl/lc_arbiter.sv
// lc_arbiter: shares the single lower-cache port between L1I and L1D.
// One transaction is outstanding at a time. Ties between the two sides are
// broken round-robin. Fill lines return only to the side that issued them.
module lc_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned LINE_BITS    = 512,
  parameter int unsigned OFFSET_BITS  = 6,
  parameter bit          RESET_PRIO_D = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_N,
  // L1I side
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_resp_valid,
  input  logic                  i_resp_ready,
  output logic [ADDR_WIDTH-1:0] i_resp_addr,
  output logic [LINE_BITS-1:0]  i_resp_data,
  // L1D side
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_we,
  input  logic [LINE_BITS-1:0]  d_req_data,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [ADDR_WIDTH-1:0] d_resp_addr,
  output logic [LINE_BITS-1:0]  d_resp_data,
  // lower-cache port
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [ADDR_WIDTH-1:0] lc_addr_out,
  output logic [LINE_BITS-1:0]  lc_value_out,
  output logic                  lc_we_out,
  input  logic                  lc_valid_in,
  output logic                  lc_ready_out,
  input  logic [ADDR_WIDTH-1:0] lc_addr_in,
  input  logic [LINE_BITS-1:0]  lc_value_in
);

  // Clears the line-offset bits of a byte address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                st;
  logic                  prio_d;     // 1: D wins the next tie
  logic                  own_d;      // owner of the current transaction
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_we;
  logic [LINE_BITS-1:0]  cap_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [LINE_BITS-1:0]  rsp_data;

  logic grant_any;
  logic grant_d;
  logic grant_i;
  logic owner_resp_ready;

  // Grant selection in IDLE; gated by reset so req_ready reads 0 while held in reset.
  always_comb begin
    grant_any        = 1'b0;
    grant_d          = 1'b0;
    grant_i          = 1'b0;
    owner_resp_ready = 1'b0;
    grant_any        = (st == ST_IDLE) && rst_N && (i_req_valid || d_req_valid);
    grant_d          = grant_any && d_req_valid && (!i_req_valid || prio_d);
    grant_i          = grant_any && !grant_d;
    owner_resp_ready = own_d ? d_resp_ready : i_resp_ready;
  end

  assign i_req_ready  = grant_i;
  assign d_req_ready  = grant_d;

  assign lc_addr_out  = cap_addr;
  assign lc_we_out    = cap_we;
  assign lc_value_out = cap_data;

  // Both sides see the same latched response; only the owner's valid is raised.
  assign i_resp_addr  = rsp_addr;
  assign i_resp_data  = rsp_data;
  assign d_resp_addr  = rsp_addr;
  assign d_resp_data  = rsp_data;

  // Transaction FSM: accept, issue to lc, wait for fill, return fill to owner.
  always_ff @(posedge clk_in or negedge rst_N) begin
    if (!rst_N) begin
      st           <= ST_IDLE;
      prio_d       <= RESET_PRIO_D;
      own_d        <= 1'b0;
      cap_addr     <= '0;
      cap_we       <= 1'b0;
      cap_data     <= '0;
      rsp_addr     <= '0;
      rsp_data     <= '0;
      lc_valid_out <= 1'b0;
      lc_ready_out <= 1'b0;
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (grant_any) begin
            own_d        <= grant_d;
            cap_addr     <= (grant_d ? d_req_addr : i_req_addr) & LINE_MASK;
            cap_we       <= grant_d & d_req_we;
            cap_data     <= (grant_d && d_req_we) ? d_req_data : '0;
            prio_d       <= !grant_d;
            lc_valid_out <= 1'b1;
            st           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lc_ready_in) begin
            lc_valid_out <= 1'b0;
            if (cap_we) begin
              st <= ST_IDLE;
            end else begin
              lc_ready_out <= 1'b1;
              st           <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lc_valid_in) begin
            lc_ready_out <= 1'b0;
            rsp_addr     <= lc_addr_in;
            rsp_data     <= lc_value_in;
            i_resp_valid <= !own_d;
            d_resp_valid <= own_d;
            st           <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_resp_ready) begin
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            st           <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc_arbiter.sv
// Directed testbench for lc_arbiter: the bench plays both L1s and the lc.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_lc_arbiter;

  logic         clk_in;
  logic         rst_N;
  logic         i_req_valid;
  logic         i_req_ready;
  logic [63:0]  i_req_addr;
  logic         i_resp_valid;
  logic         i_resp_ready;
  logic [63:0]  i_resp_addr;
  logic [511:0] i_resp_data;
  logic         d_req_valid;
  logic         d_req_ready;
  logic [63:0]  d_req_addr;
  logic         d_req_we;
  logic [511:0] d_req_data;
  logic         d_resp_valid;
  logic         d_resp_ready;
  logic [63:0]  d_resp_addr;
  logic [511:0] d_resp_data;
  logic         lc_valid_out;
  logic         lc_ready_in;
  logic [63:0]  lc_addr_out;
  logic [511:0] lc_value_out;
  logic         lc_we_out;
  logic         lc_valid_in;
  logic         lc_ready_out;
  logic [63:0]  lc_addr_in;
  logic [511:0] lc_value_in;

  int checks = 0;
  int errors = 0;

  lc_arbiter #(
    .ADDR_WIDTH  (64),
    .LINE_BITS   (512),
    .OFFSET_BITS (6),
    .RESET_PRIO_D(1'b1)
  ) dut (
    .clk_in      (clk_in),
    .rst_N       (rst_N),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_resp_valid(i_resp_valid),
    .i_resp_ready(i_resp_ready),
    .i_resp_addr (i_resp_addr),
    .i_resp_data (i_resp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_addr  (d_req_addr),
    .d_req_we    (d_req_we),
    .d_req_data  (d_req_data),
    .d_resp_valid(d_resp_valid),
    .d_resp_ready(d_resp_ready),
    .d_resp_addr (d_resp_addr),
    .d_resp_data (d_resp_data),
    .lc_valid_out(lc_valid_out),
    .lc_ready_in (lc_ready_in),
    .lc_addr_out (lc_addr_out),
    .lc_value_out(lc_value_out),
    .lc_we_out   (lc_we_out),
    .lc_valid_in (lc_valid_in),
    .lc_ready_out(lc_ready_out),
    .lc_addr_in  (lc_addr_in),
    .lc_value_in (lc_value_in)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- stimulus helpers (no checking inside) ----------------

  // Caller has raised the side's valid; wait for the accept, then drop valid.
  task automatic req_grant(input bit side_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (side_d ? d_req_ready : i_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    if (side_d) d_req_valid = 1'b0;
    else        i_req_valid = 1'b0;
  endtask

  // Act as lc: accept the next request and report what was presented.
  task automatic lc_take(output logic [63:0] addr, output logic we,
                         output logic [511:0] val, output bit ok);
    ok   = 1'b0;
    addr = '0;
    we   = 1'b0;
    val  = '0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (lc_valid_out) begin
        addr        = lc_addr_out;
        we          = lc_we_out;
        val         = lc_value_out;
        lc_ready_in = 1'b1;
        ok          = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    lc_ready_in = 1'b0;
  endtask

  // Act as lc: return a line after lat idle cycles.
  task automatic lc_resp(input int lat, input logic [63:0] addr,
                         input logic [511:0] data, output bit ok);
    repeat (lat) @(negedge clk_in);
    lc_valid_in = 1'b1;
    lc_addr_in  = addr;
    lc_value_in = data;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (lc_ready_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    lc_valid_in = 1'b0;
  endtask

  // Act as the L1: take the fill on one side, noting the other side's valid.
  task automatic resp_take(input bit side_d, output logic [63:0] addr,
                           output logic [511:0] data, output logic other,
                           output bit ok);
    ok    = 1'b0;
    addr  = '0;
    data  = '0;
    other = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (side_d ? d_resp_valid : i_resp_valid) begin
        addr  = side_d ? d_resp_addr : i_resp_addr;
        data  = side_d ? d_resp_data : i_resp_data;
        other = side_d ? i_resp_valid : d_resp_valid;
        if (side_d) d_resp_ready = 1'b1;
        else        i_resp_ready = 1'b1;
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    d_resp_ready = 1'b0;
    i_resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset;
    rst_N       = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    lc_valid_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready: got %b expected 00", {i_req_ready, d_req_ready});
    end
    checks++;
    if ({lc_valid_out, lc_ready_out, lc_we_out, i_resp_valid, d_resp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 00000",
               {lc_valid_out, lc_ready_out, lc_we_out, i_resp_valid, d_resp_valid});
    end
    checks++;
    if (lc_addr_out !== 64'h0 || i_resp_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_addr: got lc %h resp %h expected 0", lc_addr_out, i_resp_addr);
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    lc_valid_in = 1'b0;
    @(negedge clk_in);
    rst_N = 1'b1;
  endtask

  task automatic test_i_read;
    logic [511:0] pat;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    bit           ok;
    pat = {64{8'hA5}};
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h40;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL iread_accept: got %b expected 10", {i_req_ready, d_req_ready});
    end
    @(negedge clk_in);
    i_req_valid = 1'b0;
    #1;
    checks++;
    if (i_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL iread_ready_pulse: got %b expected 0", i_req_ready);
    end
    checks++;
    if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h40 || lc_we_out !== 1'b0
        || lc_value_out !== 512'h0) begin
      errors++;
      $display("FAIL iread_issue: got v%b a%h we%b expected v1 a40 we0 value0",
               lc_valid_out, lc_addr_out, lc_we_out);
    end
    lc_ready_in = 1'b1;
    @(negedge clk_in);
    lc_ready_in = 1'b0;
    #1;
    checks++;
    if (lc_ready_out !== 1'b1 || lc_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL iread_wait: got rdy%b v%b expected rdy1 v0", lc_ready_out, lc_valid_out);
    end
    lc_resp(3, 64'h40, pat, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL iread_lc_resp_timeout: got %b expected 1", ok);
    end
    #1;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_addr !== 64'h40 || i_resp_data !== pat
        || d_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL iread_resp: got iv%b a%h dv%b expected iv1 a40 dv0",
               i_resp_valid, i_resp_addr, d_resp_valid);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== pat) begin
      errors++;
      $display("FAIL iread_resp_hold: got iv%b expected 1 with data held", i_resp_valid);
    end
    resp_take(1'b0, ra, rd, oth, ok);
    #1;
    checks++;
    if (ok !== 1'b1 || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL iread_resp_done: got ok%b iv%b dv%b expected ok1 iv0 dv0",
               ok, i_resp_valid, d_resp_valid);
    end
  endtask

  task automatic test_tie;
    logic [63:0]  a;
    logic         we;
    logic [511:0] v;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    bit           ok;
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h80;
    d_req_valid = 1'b1;
    d_req_addr  = 64'h100;
    d_req_we    = 1'b0;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL tie_first_grant: got i/d %b expected 01", {i_req_ready, d_req_ready});
    end
    @(negedge clk_in);
    d_req_valid = 1'b0;
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h100 || we !== 1'b0) begin
      errors++;
      $display("FAIL tie_d_issue: got ok%b a%h we%b expected ok1 a100 we0", ok, a, we);
    end
    lc_resp(1, 64'h100, {16{32'hD00D_0100}}, ok);
    resp_take(1'b1, ra, rd, oth, ok);
    checks++;
    if (ok !== 1'b1 || ra !== 64'h100 || rd !== {16{32'hD00D_0100}} || oth !== 1'b0) begin
      errors++;
      $display("FAIL tie_d_resp: got ok%b a%h iv%b expected ok1 a100 iv0", ok, ra, oth);
    end
    req_grant(1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL tie_i_accept_timeout: got %b expected 1", ok);
    end
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h80 || we !== 1'b0) begin
      errors++;
      $display("FAIL tie_i_issue: got ok%b a%h we%b expected ok1 a80 we0", ok, a, we);
    end
    lc_resp(0, 64'h80, {16{32'h1111_0080}}, ok);
    resp_take(1'b0, ra, rd, oth, ok);
    checks++;
    if (ok !== 1'b1 || ra !== 64'h80 || rd !== {16{32'h1111_0080}} || oth !== 1'b0) begin
      errors++;
      $display("FAIL tie_i_resp: got ok%b a%h dv%b expected ok1 a80 dv0", ok, ra, oth);
    end
  endtask

  task automatic test_writeback;
    logic [63:0]  a;
    logic         we;
    logic [511:0] v;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    bit           ok;
    @(negedge clk_in);
    d_req_valid = 1'b1;
    d_req_addr  = 64'h1C7;
    d_req_we    = 1'b1;
    d_req_data  = 512'h1234;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_accept: got %b expected 1", d_req_ready);
    end
    @(negedge clk_in);
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_data  = '0;
    lc_ready_in = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = 64'h240;
    #1;
    checks++;
    if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h1C0 || lc_we_out !== 1'b1
        || lc_value_out !== 512'h1234) begin
      errors++;
      $display("FAIL wb_issue: got v%b a%h we%b val%h expected v1 a1c0 we1 val1234",
               lc_valid_out, lc_addr_out, lc_we_out, lc_value_out[31:0]);
    end
    checks++;
    if (i_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wb_no_accept_in_issue: got %b expected 0", i_req_ready);
    end
    @(negedge clk_in);
    lc_ready_in = 1'b0;
    #1;
    checks++;
    if (i_req_ready !== 1'b1 || lc_valid_out !== 1'b0 || lc_ready_out !== 1'b0
        || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wb_next_accept: got irdy%b lv%b lr%b iv%b dv%b expected 1 0 0 0 0",
               i_req_ready, lc_valid_out, lc_ready_out, i_resp_valid, d_resp_valid);
    end
    @(negedge clk_in);
    i_req_valid = 1'b0;
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h240 || we !== 1'b0 || v !== 512'h0) begin
      errors++;
      $display("FAIL wb_follow_issue: got ok%b a%h we%b expected ok1 a240 we0", ok, a, we);
    end
    lc_resp(0, 64'h240, {64{8'h3C}}, ok);
    resp_take(1'b0, ra, rd, oth, ok);
    checks++;
    if (ok !== 1'b1 || rd !== {64{8'h3C}} || oth !== 1'b0) begin
      errors++;
      $display("FAIL wb_follow_resp: got ok%b dv%b expected ok1 dv0", ok, oth);
    end
  endtask

  task automatic test_stall;
    logic [63:0]  a;
    logic         we;
    logic [511:0] v;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    bit           ok;
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h2C5;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept: got %b expected 1", i_req_ready);
    end
    @(negedge clk_in);
    i_req_addr = 64'h300;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h2C0 || lc_we_out !== 1'b0
          || lc_value_out !== 512'h0 || i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v%b a%h we%b irdy%b expected v1 a2c0 we0 irdy0",
                 c, lc_valid_out, lc_addr_out, lc_we_out, i_req_ready);
      end
      @(negedge clk_in);
    end
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h2C0) begin
      errors++;
      $display("FAIL stall_release: got ok%b a%h expected ok1 a2c0", ok, a);
    end
    lc_resp(2, 64'h2C0, {64{8'h5A}}, ok);
    resp_take(1'b0, ra, rd, oth, ok);
    checks++;
    if (ok !== 1'b1 || ra !== 64'h2C0 || rd !== {64{8'h5A}}) begin
      errors++;
      $display("FAIL stall_resp: got ok%b a%h expected ok1 a2c0", ok, ra);
    end
    req_grant(1'b0, ok);
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h300) begin
      errors++;
      $display("FAIL stall_queued_issue: got ok%b a%h expected ok1 a300", ok, a);
    end
    lc_resp(0, 64'h300, {64{8'h77}}, ok);
    resp_take(1'b0, ra, rd, oth, ok);
  endtask

  task automatic test_fairness;
    logic [63:0]  a;
    logic [63:0]  want_a;
    logic         we;
    logic [511:0] v;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    logic         who;
    bit           ok;
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h2000;
    d_req_valid = 1'b1;
    d_req_addr  = 64'h1000;
    d_req_we    = 1'b0;
    for (int t = 0; t < 6; t++) begin
      ok  = 1'b0;
      who = 1'b0;
      for (int k = 0; k < 40; k++) begin
        #1;
        if (i_req_ready || d_req_ready) begin
          who = d_req_ready;
          ok  = 1'b1;
          break;
        end
        @(negedge clk_in);
      end
      want_a = who ? d_req_addr : i_req_addr;
      checks++;
      if (ok !== 1'b1 || who !== ((t % 2) == 0)) begin
        errors++;
        $display("FAIL fair_order[%0d]: got ok%b d_won%b expected ok1 d_won%b",
                 t, ok, who, ((t % 2) == 0));
      end
      @(negedge clk_in);
      if (who) d_req_addr = d_req_addr + 64'h40;
      else     i_req_addr = i_req_addr + 64'h40;
      lc_take(a, we, v, ok);
      checks++;
      if (ok !== 1'b1 || a !== want_a) begin
        errors++;
        $display("FAIL fair_issue[%0d]: got ok%b a%h expected ok1 a%h", t, ok, a, want_a);
      end
      lc_resp(0, want_a, {8{want_a}}, ok);
      resp_take(who, ra, rd, oth, ok);
      checks++;
      if (ok !== 1'b1 || ra !== want_a || oth !== 1'b0) begin
        errors++;
        $display("FAIL fair_resp[%0d]: got ok%b a%h other%b expected ok1 a%h other0",
                 t, ok, ra, oth, want_a);
      end
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0]  a;
    logic         we;
    logic [511:0] v;
    logic [63:0]  ra;
    logic [511:0] rd;
    logic         oth;
    bit           ok;
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h400;
    req_grant(1'b0, ok);
    lc_take(a, we, v, ok);
    #1;
    checks++;
    if (lc_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_wait: got %b expected 1", lc_ready_out);
    end
    #1;
    rst_N = 1'b0;
    #1;
    checks++;
    if ({lc_valid_out, lc_ready_out, lc_we_out, i_resp_valid, d_resp_valid,
         i_req_ready, d_req_ready} !== 7'b0 || lc_addr_out !== 64'h0) begin
      errors++;
      $display("FAIL rmid_async_clear: got %b a%h expected 0000000 a0",
               {lc_valid_out, lc_ready_out, lc_we_out, i_resp_valid, d_resp_valid,
                i_req_ready, d_req_ready}, lc_addr_out);
    end
    repeat (2) @(negedge clk_in);
    rst_N = 1'b1;
    @(negedge clk_in);
    lc_valid_in = 1'b1;
    lc_addr_in  = 64'h400;
    lc_value_in = {64{8'hEE}};
    #1;
    checks++;
    if (lc_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stale_ready: got %b expected 0", lc_ready_out);
    end
    @(negedge clk_in);
    lc_valid_in = 1'b0;
    #1;
    checks++;
    if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || lc_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stale_ignored: got iv%b dv%b lv%b expected 0 0 0",
               i_resp_valid, d_resp_valid, lc_valid_out);
    end
    @(negedge clk_in);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h440;
    req_grant(1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rmid_new_accept: got %b expected 1", ok);
    end
    lc_take(a, we, v, ok);
    checks++;
    if (ok !== 1'b1 || a !== 64'h440 || we !== 1'b0) begin
      errors++;
      $display("FAIL rmid_new_issue: got ok%b a%h we%b expected ok1 a440 we0", ok, a, we);
    end
    lc_resp(1, 64'h440, {64{8'h42}}, ok);
    resp_take(1'b0, ra, rd, oth, ok);
    checks++;
    if (ok !== 1'b1 || ra !== 64'h440 || rd !== {64{8'h42}} || oth !== 1'b0) begin
      errors++;
      $display("FAIL rmid_new_resp: got ok%b a%h dv%b expected ok1 a440 dv0", ok, ra, oth);
    end
  endtask

  initial begin
    rst_N        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_resp_ready = 1'b0;
    d_req_valid  = 1'b0;
    d_req_addr   = '0;
    d_req_we     = 1'b0;
    d_req_data   = '0;
    d_resp_ready = 1'b0;
    lc_ready_in  = 1'b0;
    lc_valid_in  = 1'b0;
    lc_addr_in   = '0;
    lc_value_in  = '0;
    #1;
    test_reset;
    test_i_read;
    test_tie;
    test_writeback;
    test_stall;
    test_fairness;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
